// File: rtl/mux64_rr_arb.sv
// Two-input round-robin arbiter feeding a single 64-bit output register.
// The register supports full-rate valid/ready handoff, and each port has a saturating grant counter.
module mux64_rr_arb #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [63:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [63:0]      req1_data,
  output logic             req1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [63:0]      out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gnt0_cnt,
  output logic [CNT_W-1:0] gnt1_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   winner;
  logic   any_valid;
  logic   accept_en;
  logic   accept;

  // Arbitration: a lone requester always wins; a tie goes to the port not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    winner    = last_grant;
    any_valid = req0_valid | req1_valid;
    case ({req1_valid, req0_valid})
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = last_grant;
    endcase
  end

  always_comb begin
    state_next = state;
    accept_en  = 1'b0;
    case (state)
      EMPTY: begin
        accept_en = 1'b1;
        if (any_valid) state_next = FULL;
      end
      FULL: begin
        accept_en = out_ready;
        if (out_ready && !any_valid) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
    // The state is EMPTY during reset, so rst has to gate the readies explicitly.
    if (rst) accept_en = 1'b0;
  end

  assign accept     = accept_en & any_valid;
  assign req0_ready = accept & ~winner;
  assign req1_ready = accept & winner;
  assign sel        = winner;
  assign out_valid  = (state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // last_grant resets to 1, so the first tie after reset goes to port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= 64'h0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
      gnt0_cnt   <= '0;
      gnt1_cnt   <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments make every register sample pre-edge values, whatever the statement order.
      out_data   <= sel ? req1_data : req0_data;
      out_src    <= sel;
      last_grant <= sel;
      if (!sel && gnt0_cnt != '1) gnt0_cnt <= gnt0_cnt + CNT_W'(1);
      if (sel && gnt1_cnt != '1)  gnt1_cnt <= gnt1_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux64_rr_arb.sv
// Directed and randomized self-checking bench for mux64_rr_arb.
// A second instance with CNT_W=4 shares the same stimulus and is used to check counter saturation.
module tb_mux64_rr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, out_ready;
  logic [63:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, sel, out_valid, out_src;
  logic [63:0] out_data;
  logic [15:0] gnt0_cnt, gnt1_cnt;

  logic        s_req0_ready, s_req1_ready, s_sel, s_out_valid, s_out_src;
  logic [63:0] s_out_data;
  logic [3:0]  s_gnt0_cnt, s_gnt1_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux64_rr_arb #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
  );

  mux64_rr_arb #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_req1_ready),
    .sel(s_sel), .out_valid(s_out_valid), .out_data(s_out_data), .out_src(s_out_src),
    .out_ready(out_ready), .gnt0_cnt(s_gnt0_cnt), .gnt1_cnt(s_gnt1_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #3 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  logic        m_full, m_lg, m_win, m_any, m_acc;
  int          m_cnt0, m_cnt1;
  logic [64:0] sb_q[$];
  logic [64:0] sb_front;

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    req0_data  = 64'h0;
    req1_data  = 64'h0;
    out_ready  = 1'b1;

    // Reset state, with a request already pending.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_gnt0", gnt0_cnt, 0);
    check("rst_gnt1", gnt1_cnt, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    req0_valid = 1'b0;
    #11 rst = 1'b0;
    tick();

    // Both requesters valid, continuous out_ready: 0,1,0 starting with port 0.
    req0_valid = 1'b1; req0_data = 64'hA5A5_0000_0000_0001;
    req1_valid = 1'b1; req1_data = 64'h5A5A_0000_0000_0002;
    out_ready  = 1'b1;
    #1;
    check("first_sel", sel, 0);
    check("first_req0_ready", req0_ready, 1);
    check("first_req1_ready", req1_ready, 0);
    tick();
    check("alt0_valid", out_valid, 1);
    check("alt0_data", out_data, 64'hA5A5_0000_0000_0001);
    check("alt0_src", out_src, 0);
    check("alt0_next_req1_ready", req1_ready, 1);
    check("alt0_next_req0_ready", req0_ready, 0);
    tick();
    check("alt1_data", out_data, 64'h5A5A_0000_0000_0002);
    check("alt1_src", out_src, 1);
    tick();
    check("alt2_data", out_data, 64'hA5A5_0000_0000_0001);
    check("alt2_src", out_src, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("alt_drain_valid", out_valid, 0);
    check("alt_gnt0", gnt0_cnt, 2);
    check("alt_gnt1", gnt1_cnt, 1);

    // Only port 1 valid for three cycles.
    pulse_reset();
    tick();
    req1_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_data = 64'h1111_0000_0000_0000 + 64'(i);
      tick();
      check("solo1_valid", out_valid, 1);
      check("solo1_src", out_src, 1);
      check("solo1_data", out_data, 64'h1111_0000_0000_0000 + 64'(i));
    end
    req1_valid = 1'b0;
    tick();
    check("solo1_drain_valid", out_valid, 0);
    check("solo1_gnt1", gnt1_cnt, 3);
    check("solo1_gnt0", gnt0_cnt, 0);

    // Backpressure: FULL with out_ready=0 for five cycles.
    req0_valid = 1'b1; req0_data = 64'hC0DE_0000_0000_0001; out_ready = 1'b0;
    tick();
    check("bp_fill_valid", out_valid, 1);
    req0_data = 64'hC0DE_0000_0000_0002;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_req0_ready", req0_ready, 0);
      check("bp_hold_data", out_data, 64'hC0DE_0000_0000_0001);
      check("bp_hold_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", req0_ready, 1);
    tick();
    check("bp_release_data", out_data, 64'hC0DE_0000_0000_0002);
    check("bp_release_src", out_src, 0);
    req0_valid = 1'b0;
    tick();
    check("bp_drain_valid", out_valid, 0);
    check("bp_gnt0", gnt0_cnt, 2);

    // Twenty port-0 transfers: the 4-bit counter saturates, the 16-bit one does not.
    req0_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req0_data = 64'hBEEF_0000_0000_0000 | 64'(i);
      tick();
    end
    check("sat_last_data", out_data, 64'hBEEF_0000_0000_0013);
    check("sat_gnt0_4bit", s_gnt0_cnt, 4'hF);
    check("sat_gnt0_16bit", gnt0_cnt, 22);
    check("sat_gnt1_4bit", s_gnt1_cnt, 3);
    req0_valid = 1'b0;
    tick();

    // Asynchronous reset while a payload is held.
    req0_valid = 1'b1; req0_data = 64'hD000_0000_0000_0000;
    req1_valid = 1'b1; req1_data = 64'hD100_0000_0000_0000;
    out_ready  = 1'b0;
    tick();
    check("arst_pre_valid", out_valid, 1);
    check("arst_pre_src", out_src, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_gnt0", gnt0_cnt, 0);
    check("arst_gnt1", gnt1_cnt, 0);
    check("arst_req0_ready", req0_ready, 0);
    check("arst_req1_ready", req1_ready, 0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("arst_tie_sel", sel, 0);
    tick();
    check("arst_tie_src", out_src, 0);
    check("arst_tie_data", out_data, 64'hD000_0000_0000_0000);
    check("arst_tie_gnt0", gnt0_cnt, 1);

    // A requester withdrawing without ready is neither counted nor latched.
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 64'hDEAD_0000_0000_0000;
    out_ready  = 1'b0;
    #1;
    check("wd_req1_ready", req1_ready, 0);
    tick();
    req1_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("wd_valid", out_valid, 0);
    check("wd_data", out_data, 64'hD000_0000_0000_0000);
    check("wd_gnt1", gnt1_cnt, 0);
    check("wd_gnt0", gnt0_cnt, 1);

    // Randomized valid/ready run against a reference model and an in-order scoreboard.
    pulse_reset();
    tick();
    m_full = 1'b0; m_lg = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
    for (int cyc = 0; cyc <= 10000; cyc++) begin
      if (cyc == 10000) begin
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
      end else begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req1_valid = ($urandom_range(0, 3) != 0);
        out_ready  = ($urandom_range(0, 9) < 7);
        req0_data  = {$urandom, $urandom};
        req1_data  = {$urandom, $urandom};
      end
      #1;
      m_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) m_win = ~m_lg;
      else if (req0_valid)          m_win = 1'b0;
      else if (req1_valid)          m_win = 1'b1;
      else                          m_win = m_lg;
      m_acc = m_any && (!m_full || out_ready);
      check("rnd_req0_ready", req0_ready, m_acc && !m_win);
      check("rnd_req1_ready", req1_ready, m_acc && m_win);
      check("rnd_ready_onehot", req0_ready & req1_ready, 0);
      check("rnd_out_valid", out_valid, m_full);
      if (m_full && out_ready) begin
        if (sb_q.size() == 0) begin
          check("rnd_sb_underflow", 1, 0);
        end else begin
          sb_front = sb_q.pop_front();
          check("rnd_sb_data", out_data, sb_front[63:0]);
          check("rnd_sb_src", out_src, sb_front[64]);
        end
      end
      if (m_acc) begin
        sb_q.push_back({m_win, m_win ? req1_data : req0_data});
        m_lg = m_win;
        if (m_win) m_cnt1++;
        else       m_cnt0++;
        m_full = 1'b1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
      tick();
    end
    check("rnd_final_valid", out_valid, 0);
    check("rnd_sb_empty", sb_q.size(), 0);
    check("rnd_gnt0", gnt0_cnt, m_cnt0);
    check("rnd_gnt1", gnt1_cnt, m_cnt1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
